// File: rtl/tl_pkg.sv
// Shared definitions for the light conflict monitor: lamp codes, monitor
// states, fault_code bit positions and the list of conflicting approach pairs.
package tl_pkg;

    // Lamp codes as driven on every approach
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        FAULT   = 2'd1,
        RECOVER = 2'd2
    } state_t;

    // fault_code bit positions
    localparam int FC_ENC  = 0;
    localparam int FC_CONF = 1;
    localparam int FC_SKIP = 2;

    // Approach indices into the packed lights vector
    localparam int NUM_APPR = 4;
    localparam logic [1:0] A_M1 = 2'd0;
    localparam logic [1:0] A_M2 = 2'd1;
    localparam logic [1:0] A_MT = 2'd2;
    localparam logic [1:0] A_S  = 2'd3;

    typedef logic [NUM_APPR-1:0][2:0] lights_t;

    // Pairs that must never both show a non-red code.
    // M1-M2 and M1-MT run together legitimately and are not listed.
    localparam int NUM_PAIRS = 4;
    localparam logic [NUM_PAIRS-1:0][1:0] PAIR_A = {A_MT, A_S,  A_S,  A_S};
    localparam logic [NUM_PAIRS-1:0][1:0] PAIR_B = {A_M2, A_MT, A_M2, A_M1};

    function automatic logic legal_code(input logic [2:0] c);
        return (c == RED) || (c == YEL) || (c == GRN);
    endfunction

endpackage

// File: rtl/tl_flasher.sv
// Half-period counter and phase toggle for the all-yellow fault flash.
// restart forces the "on" phase with a fresh count; phase_next is the phase
// that will be held after the current edge, so the caller can register lamps
// in step with it.
module tl_flasher #(
    parameter int FLASH_HALF = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic enable,
    output logic phase_next
);

    localparam int FW = $clog2(FLASH_HALF + 1);

    logic [FW-1:0] fcnt;
    logic          phase;
    logic          wrap;

    assign wrap = (fcnt == FW'(FLASH_HALF - 1));

    // Phase seen after this edge
    always_comb begin
        phase_next = phase;
        if (restart)
            phase_next = 1'b1;
        else if (enable && wrap)
            phase_next = ~phase;
    end

    // Count 0..FLASH_HALF-1 and toggle the phase on each wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt  <= '0;
            phase <= 1'b0;
        end else if (restart) begin
            fcnt  <= '0;
            phase <= 1'b1;
        end else if (enable) begin
            phase <= phase_next;
            if (wrap)
                fcnt <= '0;
            else
                fcnt <= fcnt + 1'b1;
        end
    end

endmodule

// File: rtl/light_conflict_monitor.sv
// Safety stage between the traffic-light controller and the lamp drivers.
// Registers the controller codes, passes clean codes through, and on a
// confirmed illegal encoding, conflict or green-to-red skip latches a fault,
// flashes yellow, and recovers through an all-red interval on operator clear.
module light_conflict_monitor
    import tl_pkg::*;
#(
    parameter int FILTER_CYCLES  = 2,
    parameter int FLASH_HALF     = 4,
    parameter int ALL_RED_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light_M1,
    input  logic [2:0] light_M2,
    input  logic [2:0] light_MT,
    input  logic [2:0] light_S,
    input  logic       fault_clr,
    output logic [2:0] lamp_M1,
    output logic [2:0] lamp_M2,
    output logic [2:0] lamp_MT,
    output logic [2:0] lamp_S,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam int VW = $clog2(FILTER_CYCLES + 1);
    localparam int RW = $clog2(ALL_RED_CYCLES + 1);

    state_t        state;
    lights_t       raw;
    lights_t       in_q;
    lights_t       prev_q;
    lights_t       lamp_q;
    logic [VW-1:0] vcnt;
    logic [RW-1:0] rcnt;

    logic          enc;
    logic          conf;
    logic          skip;
    logic          viol;
    logic          v_conf;
    logic [2:0]    flags;
    logic          fault_entry;
    logic          phase_next;
    logic [NUM_APPR-1:0] nonred;

    assign raw = {light_S, light_MT, light_M2, light_M1};

    // Encoding, right-of-way and skip-yellow checks on the registered codes
    always_comb begin
        enc    = 1'b0;
        conf   = 1'b0;
        skip   = 1'b0;
        nonred = '0;
        for (int i = 0; i < NUM_APPR; i++) begin
            if (!legal_code(in_q[i]))
                enc = 1'b1;
            nonred[i] = (in_q[i] != RED);
            if (prev_q[i] == GRN && in_q[i] == RED)
                skip = 1'b1;
        end
        for (int p = 0; p < NUM_PAIRS; p++) begin
            if (nonred[PAIR_A[p]] && nonred[PAIR_B[p]])
                conf = 1'b1;
        end
        // Skip-yellow only means something while lamps are following inputs
        skip = skip && (state == NORMAL);
    end

    assign viol   = enc | conf;
    assign v_conf = viol && (vcnt == VW'(FILTER_CYCLES - 1));

    // Flags contributed to fault_code by a confirmation this cycle
    always_comb begin
        flags          = 3'b000;
        flags[FC_ENC]  = enc && v_conf;
        flags[FC_CONF] = conf && v_conf;
        flags[FC_SKIP] = skip;
    end

    assign fault_entry = ((state == NORMAL) && (v_conf || skip)) ||
                         ((state == RECOVER) && v_conf);

    tl_flasher #(
        .FLASH_HALF (FLASH_HALF)
    ) u_flasher (
        .clk        (clk),
        .rst        (rst),
        .restart    (fault_entry),
        .enable     (state == FAULT),
        .phase_next (phase_next)
    );

    // Monitor state machine: input stage, violation filter, lamps and flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= NORMAL;
            in_q       <= {NUM_APPR{RED}};
            prev_q     <= {NUM_APPR{RED}};
            lamp_q     <= {NUM_APPR{RED}};
            vcnt       <= '0;
            rcnt       <= '0;
            fault      <= 1'b0;
            fault_code <= 3'b000;
        end else begin
            in_q <= raw;

            // Saturates at the confirm value so a persisting violation
            // stays confirmed without wrapping
            if (!viol)
                vcnt <= '0;
            else if (vcnt != VW'(FILTER_CYCLES - 1))
                vcnt <= vcnt + 1'b1;

            case (state)
                NORMAL: begin
                    if (fault_entry) begin
                        state      <= FAULT;
                        fault      <= 1'b1;
                        fault_code <= fault_code | flags;
                        lamp_q     <= {NUM_APPR{YEL}};
                    end else if (!viol) begin
                        lamp_q <= in_q;
                        prev_q <= in_q;
                    end
                end
                FAULT: begin
                    if (fault_clr) begin
                        state  <= RECOVER;
                        lamp_q <= {NUM_APPR{RED}};
                        rcnt   <= '0;
                    end else begin
                        lamp_q <= phase_next ? {NUM_APPR{YEL}} : {NUM_APPR{OFF}};
                    end
                end
                RECOVER: begin
                    if (fault_entry) begin
                        state      <= FAULT;
                        fault_code <= fault_code | flags;
                        lamp_q     <= {NUM_APPR{YEL}};
                    end else if (!viol && rcnt == RW'(ALL_RED_CYCLES - 1)) begin
                        state      <= NORMAL;
                        fault      <= 1'b0;
                        fault_code <= 3'b000;
                        vcnt       <= '0;
                        prev_q     <= {NUM_APPR{RED}};
                        lamp_q     <= {NUM_APPR{RED}};
                    end else begin
                        lamp_q <= {NUM_APPR{RED}};
                        if (rcnt != RW'(ALL_RED_CYCLES - 1))
                            rcnt <= rcnt + 1'b1;
                    end
                end
                default: state <= NORMAL;
            endcase
        end
    end

    assign lamp_M1 = lamp_q[A_M1];
    assign lamp_M2 = lamp_q[A_M2];
    assign lamp_MT = lamp_q[A_MT];
    assign lamp_S  = lamp_q[A_S];

endmodule

// File: tb/tb_light_conflict_monitor.sv
// Directed bench for light_conflict_monitor with hand-computed lamp vectors.
// Lamp/input vectors are packed {M1, M2, MT, S}, three bits each.
`timescale 1ns/1ps
module tb_light_conflict_monitor;

    localparam logic [11:0] L_RED = 12'h924; // all 100
    localparam logic [11:0] L_YEL = 12'h492; // all 010
    localparam logic [11:0] L_OFF = 12'h000;
    localparam logic [11:0] V_A   = 12'h264; // M1=001 M2=001 MT=100 S=100
    localparam logic [11:0] V_B   = 12'h4A4; // M1=010 M2=010 MT=100 S=100
    localparam logic [11:0] V_G1  = 12'h261; // M1=001 M2=001 MT=100 S=001
    localparam logic [11:0] V_C2  = 12'h4A1; // M1=010 M2=010 MT=100 S=001
    localparam logic [11:0] V_ENC = 12'h2E4; // M1=001 M2=011 MT=100 S=100
    localparam logic [11:0] V_T1  = 12'h30C; // M1=001 M2=100 MT=001 S=100
    localparam logic [11:0] V_T2  = 12'h324; // M1=001 M2=100 MT=100 S=100
    localparam logic [11:0] V_RC  = 12'h861; // M1=100 M2=001 MT=100 S=001

    logic       clk;
    logic       rst;
    logic [2:0] light_M1, light_M2, light_MT, light_S;
    logic       fault_clr;
    logic [2:0] lamp_M1, lamp_M2, lamp_MT, lamp_S;
    logic       fault;
    logic [2:0] fault_code;
    logic [11:0] lamps;

    int n_cmp = 0;
    int n_err = 0;

    light_conflict_monitor #(
        .FILTER_CYCLES  (2),
        .FLASH_HALF     (4),
        .ALL_RED_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .light_M1   (light_M1),
        .light_M2   (light_M2),
        .light_MT   (light_MT),
        .light_S    (light_S),
        .fault_clr  (fault_clr),
        .lamp_M1    (lamp_M1),
        .lamp_M2    (lamp_M2),
        .lamp_MT    (lamp_MT),
        .lamp_S     (lamp_S),
        .fault      (fault),
        .fault_code (fault_code)
    );

    assign lamps = {lamp_M1, lamp_M2, lamp_MT, lamp_S};

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input logic [11:0] v);
        {light_M1, light_M2, light_MT, light_S} = v;
    endtask

    // Advance one rising edge and settle
    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [11:0] l, input logic f, input logic [2:0] c);
        check({tag, ".lamps"}, {4'h0, lamps}, {4'h0, l});
        check({tag, ".fault"}, {15'h0, fault}, {15'h0, f});
        check({tag, ".code"},  {13'h0, fault_code}, {13'h0, c});
    endtask

    // Operator clear from FAULT with all-red inputs, through to NORMAL
    task automatic do_recover(input string tag, input logic [2:0] code_in_fault);
        set_in(L_RED);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        check_out({tag, ".rec0"}, L_RED, 1'b1, code_in_fault);
        step(7);
        check_out({tag, ".rec7"}, L_RED, 1'b1, code_in_fault);
        step();
        check_out({tag, ".done"}, L_RED, 1'b0, 3'b000);
    endtask

    initial begin
        rst       = 1'b1;
        fault_clr = 1'b0;
        set_in(L_RED);
        step(2);
        check_out("reset", L_RED, 1'b0, 3'b000);
        rst = 1'b0;

        // Pass-through with two-edge latency
        set_in(V_A);
        step();
        check_out("pass1", L_RED, 1'b0, 3'b000);
        step();
        check_out("pass2", V_A, 1'b0, 3'b000);

        // Single-cycle conflict is filtered; lamps hold the prior legal value
        set_in(V_G1);
        step();
        set_in(V_B);
        step();
        check_out("glitch_hold", V_A, 1'b0, 3'b000);
        step();
        check_out("glitch_after", V_B, 1'b0, 3'b000);

        // Conflict held two cycles -> FAULT, then flash 4 on / 4 off
        set_in(V_C2);
        step();
        step();
        check_out("conf_pending", V_B, 1'b0, 3'b000);
        set_in(L_RED);
        step();
        check_out("conf_fault", L_YEL, 1'b1, 3'b010);
        step(3);
        check("flash_on_last", {4'h0, lamps}, {4'h0, L_YEL});
        step();
        check("flash_off_first", {4'h0, lamps}, {4'h0, L_OFF});
        step(3);
        check("flash_off_last", {4'h0, lamps}, {4'h0, L_OFF});
        step();
        check_out("flash_on_again", L_YEL, 1'b1, 3'b010);

        // Clear, all-red interval, then lamps follow the inputs again
        do_recover("clr1", 3'b010);
        set_in(V_A);
        step();
        check_out("follow1", L_RED, 1'b0, 3'b000);
        step();
        check_out("follow2", V_A, 1'b0, 3'b000);

        // fault_clr has no effect in NORMAL
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        check_out("clr_ignored", V_A, 1'b0, 3'b000);

        // Illegal encoding on M2 held two cycles
        set_in(V_ENC);
        step();
        step();
        check_out("enc_pending", V_A, 1'b0, 3'b000);
        set_in(V_A);
        step();
        check_out("enc_fault", L_YEL, 1'b1, 3'b001);
        do_recover("clr2", 3'b001);

        // Green straight to red on MT, no filter
        set_in(V_T1);
        step(2);
        check_out("mt_green", V_T1, 1'b0, 3'b000);
        set_in(V_T2);
        step();
        check_out("skip_pending", V_T1, 1'b0, 3'b000);
        step();
        check_out("skip_fault", L_YEL, 1'b1, 3'b100);

        // Conflict held two cycles inside RECOVER returns to FAULT
        set_in(L_RED);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        check_out("rec_start", L_RED, 1'b1, 3'b100);
        step();
        set_in(V_RC);
        step();
        check_out("rec_conf0", L_RED, 1'b1, 3'b100);
        step();
        check_out("rec_conf1", L_RED, 1'b1, 3'b100);
        set_in(L_RED);
        step();
        check_out("rec_refault", L_YEL, 1'b1, 3'b110);

        // Asynchronous reset while flashing on
        #3;
        rst = 1'b1;
        #1;
        check_out("async_rst", L_RED, 1'b0, 3'b000);
        #2;
        rst = 1'b0;
        set_in(V_A);
        step();
        check_out("post_rst1", L_RED, 1'b0, 3'b000);
        step();
        check_out("post_rst2", V_A, 1'b0, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/light_conflict_monitor.md
Name: light_conflict_monitor

Overview:
- Safety stage directly downstream of the four-approach traffic-light controller.
- Samples the controller's per-approach lamp codes (M1, M2, MT, S) and passes them to the lamp drivers.
- Checks the codes for illegal encodings, conflicting right-of-way and green-to-red without yellow.
- On a confirmed violation it latches a fault, flashes all approaches yellow, and recovers through an all-red interval on operator clear.

Parameters:
FILTER_CYCLES, 2, consecutive sampled cycles an encoding/conflict violation must persist before it is confirmed (>=1)
FLASH_HALF, 4, cycles per on/off half-period of the fault flash (>=1)
ALL_RED_CYCLES, 8, cycles of all-red held in RECOVER before returning to NORMAL (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
light_M1  in  3  controller code, main road 1 (100 red, 010 yellow, 001 green)
light_M2  in  3  controller code, main road 2
light_MT  in  3  controller code, main-road turn
light_S  in  3  controller code, side road
fault_clr  in  1  operator clear; sampled only in FAULT
lamp_M1  out  3  driven lamp code, M1
lamp_M2  out  3  driven lamp code, M2
lamp_MT  out  3  driven lamp code, MT
lamp_S  out  3  driven lamp code, S
fault  out  1  high in FAULT and RECOVER
fault_code  out  3  sticky flags: bit0 illegal encoding, bit1 conflict, bit2 skip-yellow

Behaviour:
- Reset (async) values:
  - state=NORMAL.
  - All lamp_* = 100 (red).
  - Input registers in_q and previous-accepted registers prev_q = 100.
  - All counters = 0; fault = 0; fault_code = 000.
- Stage 1: every edge, in_q <= light_* (all four approaches).
- Checks, evaluated combinationally on in_q:
  - enc: any approach not exactly 100, 010 or 001.
  - conf: both members of any pair are non-red. Pairs: S-M1, S-M2, S-MT, MT-M2. M1-M2 and M1-MT are permitted.
  - skip: any approach with prev_q=001 and in_q=100. Checked in NORMAL only.
- Violation filter (enc|conf):
  - vcnt increments each edge the violation is present and resets to 0 on a clean cycle.
  - Confirmed when the violation is present and vcnt==FILTER_CYCLES-1.
  - Inputs registered into in_q at edge k and violating through edge k+FILTER_CYCLES-1 → FAULT entered at edge k+FILTER_CYCLES.
  - skip bypasses the filter: confirmed at the first edge it is seen.
- NORMAL:
  - Clean in_q: lamp_* <= in_q and prev_q <= in_q. Latency input→lamp is 2 edges.
  - Unconfirmed violation: lamp_* and prev_q hold their last values.
  - Confirmed violation: state <= FAULT; fault_code |= offending flags; lamps <= 010 on all approaches; flash phase = on; fcnt = 0.
- FAULT:
  - fault=1.
  - fcnt counts 0..FLASH_HALF-1, then wraps and toggles the phase.
  - Phase on: all lamps 010. Phase off: all lamps 000.
  - fault_clr high at an edge → RECOVER, all lamps 100, rcnt=0. Otherwise FAULT holds indefinitely.
- RECOVER:
  - fault=1; all lamps 100; rcnt increments.
  - A confirmed enc/conf violation (vcnt keeps running) → back to FAULT, flags OR'd into fault_code. This takes priority over completion.
  - rcnt==ALL_RED_CYCLES-1 with no violation → NORMAL. At that edge: fault_code=000, vcnt=0, prev_q=100, lamps <= 100 (first pass-through on the next edge).
- fault_clr is ignored in NORMAL and RECOVER.
- Simultaneous enc+conf at confirmation sets both bits.
- Counter widths: $clog2(param+1). No wrap occurs except fcnt.
- rst mid-operation returns every register to its reset value immediately.

Decomposition:
- Shared package tl_pkg contains:
  - lamp code constants: RED=100, YEL=010, GRN=001, OFF=000
  - the state enum: NORMAL, FAULT, RECOVER
  - fault_code bit indices
  - the conflict-pair list
- One sub-module, tl_flasher: FLASH_HALF counter plus phase toggle, with a restart input. It is restarted on FAULT entry.

Test Plan:
- Reset, then inputs M1=001, M2=001, MT=100, S=100 → lamps match on the 2nd edge; fault=0, fault_code=000.
- S=001 with M1=001 for 1 cycle (FILTER_CYCLES=2), then legal → no fault; lamps hold the prior legal value for that cycle. Held 2 cycles → fault=1, fault_code=010; lamps all 010 for 4 cycles, then 000 for 4 cycles, repeating.
- M2=011 for 2 cycles → fault_code=001, flashing starts.
- MT sequence 001 then 100 with no yellow → FAULT on the next edge, fault_code=100.
- In FAULT, pulse fault_clr with legal inputs → lamps all 100 for 8 cycles, then fault=0, code=000, and lamps follow the inputs. Repeat with a conflict held 2 cycles inside RECOVER → returns to FAULT with code bit1 set.
- Assert rst while in FAULT (phase on) → same cycle all lamps 100, fault=0, fault_code=000.
